// File: rtl/afpm_io_sequencer.sv
// afpm_io_sequencer: byte-serial operand/result sequencer for the logarithmic
// approximate FP16 multiplier core. Operands arrive low byte first on
// a_byte/b_byte. The 16-bit result is returned low byte first on out_byte.
// Optional feature: define AFPM_ZERO_SKIP_EN to bypass the core when either
// operand is zero or subnormal. The result is then a correctly signed zero.
module afpm_io_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  input  logic [7:0]  a_byte,
  input  logic [7:0]  b_byte,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [15:0] NAN_RESULT  = 16'h7E00;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_HI = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OUT_LO  = 3'd4,
    ST_OUT_HI  = 3'd5
  } state_t;

`ifdef AFPM_ZERO_SKIP_EN
  // A zero exponent field means the operand is zero or subnormal, so it is flushed to zero.
  function automatic logic exp_is_zero(input logic [4:0] exp_field);
    return (exp_field == 5'd0);
  endfunction
`endif

  state_t      state_r, state_s;
  logic [15:0] op_a_r, op_a_s;
  logic [15:0] op_b_r, op_b_s;
  logic [15:0] result_r, result_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        err_r, err_s;
  logic        mul_start_r, mul_start_s;
  logic [7:0]  out_byte_r, out_byte_s;
  logic        out_valid_r, out_valid_s;
  logic        out_last_r, out_last_s;
  logic        busy_r, busy_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s     = state_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
    result_s    = result_r;
    cnt_s       = cnt_r;
    err_s       = err_r;
    mul_start_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_s  = {op_a_r[15:8], a_byte};
          op_b_s  = {op_b_r[15:8], b_byte};
          err_s   = 1'b0;
          state_s = ST_LOAD_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_HI: begin
        if (in_valid) begin
          op_a_s  = {a_byte, op_a_r[7:0]};
          op_b_s  = {b_byte, op_b_r[7:0]};
          state_s = ST_START;
`ifdef AFPM_ZERO_SKIP_EN
          // The start pulse is registered, so the skip decision uses the incoming high bytes.
          mul_start_s = ~(exp_is_zero(a_byte[6:2]) | exp_is_zero(b_byte[6:2]));
`else
          mul_start_s = 1'b1;
`endif
        end else begin
          state_s = ST_LOAD_HI;
        end
      end
      ST_START: begin
        cnt_s = 8'd0;
`ifdef AFPM_ZERO_SKIP_EN
        if (exp_is_zero(op_a_r[14:10]) || exp_is_zero(op_b_r[14:10])) begin
          result_s = {op_a_r[15] ^ op_b_r[15], 15'd0};
          state_s  = ST_OUT_LO;
        end else begin
          state_s  = ST_WAIT;
        end
`else
        state_s = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        // A done on the final timeout cycle still wins, so the check order matters.
        if (mul_done) begin
          result_s = mul_result;
          state_s  = ST_OUT_LO;
        end else if (cnt_r == TIMEOUT_CNT) begin
          result_s = NAN_RESULT;
          err_s    = 1'b1;
          state_s  = ST_OUT_LO;
        end else begin
          cnt_s    = cnt_r + 8'd1;
          state_s  = ST_WAIT;
        end
      end
      ST_OUT_LO: state_s = ST_OUT_HI;
      ST_OUT_HI: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    out_valid_s = (state_s == ST_OUT_LO) || (state_s == ST_OUT_HI);
    out_last_s  = (state_s == ST_OUT_HI);
    busy_s      = (state_s != ST_IDLE) && (state_s != ST_LOAD_HI);

    case (state_s)
      ST_OUT_LO: out_byte_s = result_s[7:0];
      ST_OUT_HI: out_byte_s = result_s[15:8];
      default:   out_byte_s = out_byte_r;
    endcase
  end

  // FSM state register; ena=0 freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (ena) begin
      state_r <= state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Operand, result, counter and output registers; ena=0 freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r      <= 16'd0;
      op_b_r      <= 16'd0;
      result_r    <= 16'd0;
      cnt_r       <= 8'd0;
      err_r       <= 1'b0;
      mul_start_r <= 1'b0;
      out_byte_r  <= 8'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else if (ena) begin
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      result_r    <= result_s;
      cnt_r       <= cnt_s;
      err_r       <= err_s;
      mul_start_r <= mul_start_s;
      out_byte_r  <= out_byte_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
    end else begin
      op_a_r      <= op_a_r;
      op_b_r      <= op_b_r;
      result_r    <= result_r;
      cnt_r       <= cnt_r;
      err_r       <= err_r;
      mul_start_r <= mul_start_r;
      out_byte_r  <= out_byte_r;
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
      busy_r      <= busy_r;
    end
  end

  assign op_a        = op_a_r;
  assign op_b        = op_b_r;
  assign mul_start   = mul_start_r;
  assign out_byte    = out_byte_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_afpm_io_sequencer.sv
// Testbench for afpm_io_sequencer. Table-driven transactions use an inline core
// model. Reset values and mid-transaction reset are checked by hand-written sequences.
module tb_afpm_io_sequencer;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_result;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  afpm_io_sequencer #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_valid    (in_valid),
    .a_byte      (a_byte),
    .b_byte      (b_byte),
    .op_a        (op_a),
    .op_b        (op_b),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          stall;     // idle cycles in LOAD_HI
    int          d;         // core done delay after START, 0 = never
    logic [15:0] res;       // core result
    int          gap;       // ena=0 cycles during OUT_LO
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
    logic        exp_err;
    int          exp_lat;   // cycles from START to OUT_LO
    int          exp_start; // mul_start pulses in the transaction
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int idx, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL v%0d %s: actual=%0h required=%0h", idx, name, act, req);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int cyc;
    int starts;
    // Low byte accepted in IDLE.
    in_valid = 1'b1;
    a_byte   = v.a[7:0];
    b_byte   = v.b[7:0];
    tick();
    check(idx, "err_clear_on_accept", {31'd0, err_timeout}, 32'd0);
    check(idx, "busy_load_hi", {31'd0, busy}, 32'd0);
    // Stall in LOAD_HI with junk on the byte lanes.
    for (int i = 0; i < v.stall; i++) begin
      in_valid = 1'b0;
      a_byte   = 8'hA5;
      b_byte   = 8'h5A;
      tick();
    end
    if (v.stall > 0) begin
      check(idx, "stall_no_start", {31'd0, mul_start}, 32'd0);
      check(idx, "stall_busy", {31'd0, busy}, 32'd0);
    end
    // High byte accepted; next cycle is START.
    in_valid = 1'b1;
    a_byte   = v.a[15:8];
    b_byte   = v.b[15:8];
    tick();
    check(idx, "start_pulse", {31'd0, mul_start}, 32'(v.exp_start));
    check(idx, "op_a_at_start", {16'd0, op_a}, {16'd0, v.a});
    check(idx, "op_b_at_start", {16'd0, op_b}, {16'd0, v.b});
    check(idx, "busy_start", {31'd0, busy}, 32'd1);
    starts = mul_start ? 1 : 0;
    // Junk bytes presented with in_valid=1 while busy must be dropped.
    a_byte = 8'hFF;
    b_byte = 8'hEE;
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      mul_done   = (v.d != 0) && (cyc == v.d);
      mul_result = mul_done ? v.res : 16'hDEAD;
      tick();
      cyc++;
      if (mul_start) starts++;
    end
    mul_done   = 1'b0;
    mul_result = 16'h0000;
    check(idx, "latency_to_out_lo", 32'(cyc), 32'(v.exp_lat));
    check(idx, "out_lo_byte", {24'd0, out_byte}, {24'd0, v.exp_lo});
    check(idx, "out_lo_last", {31'd0, out_last}, 32'd0);
    check(idx, "err_at_out_lo", {31'd0, err_timeout}, {31'd0, v.exp_err});
    // Optional freeze in OUT_LO.
    for (int i = 0; i < v.gap; i++) begin
      ena = 1'b0;
      tick();
      if (mul_start) starts++;
      check(idx, "freeze_valid", {31'd0, out_valid}, 32'd1);
      check(idx, "freeze_byte", {24'd0, out_byte}, {24'd0, v.exp_lo});
      check(idx, "freeze_last", {31'd0, out_last}, 32'd0);
    end
    ena = 1'b1;
    tick();
    if (mul_start) starts++;
    check(idx, "out_hi_valid", {31'd0, out_valid}, 32'd1);
    check(idx, "out_hi_last", {31'd0, out_last}, 32'd1);
    check(idx, "out_hi_byte", {24'd0, out_byte}, {24'd0, v.exp_hi});
    check(idx, "op_a_stable", {16'd0, op_a}, {16'd0, v.a});
    check(idx, "op_b_stable", {16'd0, op_b}, {16'd0, v.b});
    // Back to IDLE with no new input.
    in_valid = 1'b0;
    tick();
    if (mul_start) starts++;
    check(idx, "idle_valid", {31'd0, out_valid}, 32'd0);
    check(idx, "idle_busy", {31'd0, busy}, 32'd0);
    check(idx, "idle_byte_hold", {24'd0, out_byte}, {24'd0, v.exp_hi});
    check(idx, "idle_err_sticky", {31'd0, err_timeout}, {31'd0, v.exp_err});
    check(idx, "start_pulse_count", 32'(starts), 32'(v.exp_start));
  endtask

  initial begin
    //          a         b         stl d   res       gap lo     hi     err   lat start
    vecs[0] = '{16'h44DF, 16'h483D, 0, 3,  16'h5129, 0, 8'h29, 8'h51, 1'b0, 4,  1}; // nominal
    vecs[1] = '{16'h3C00, 16'h4000, 4, 1,  16'h4000, 0, 8'h00, 8'h40, 1'b0, 2,  1}; // stall
    vecs[2] = '{16'h4200, 16'h4400, 0, 0,  16'h0000, 0, 8'h00, 8'h7E, 1'b1, 17, 1}; // timeout
    vecs[3] = '{16'h4000, 16'h4000, 0, 2,  16'h4400, 0, 8'h00, 8'h44, 1'b0, 3,  1}; // err clears
    vecs[4] = '{16'h3C00, 16'h3C00, 0, 16, 16'h3C00, 0, 8'h00, 8'h3C, 1'b0, 17, 1}; // done on timeout cycle
    vecs[5] = '{16'h4500, 16'h4600, 0, 1,  16'h4F80, 3, 8'h80, 8'h4F, 1'b0, 2,  1}; // ena freeze
`ifdef AFPM_ZERO_SKIP_EN
    vecs[6] = '{16'h8000, 16'h3C00, 0, 1,  16'h8000, 0, 8'h00, 8'h80, 1'b0, 1,  0}; // zero skip
`else
    vecs[6] = '{16'h8000, 16'h3C00, 0, 1,  16'h8000, 0, 8'h00, 8'h80, 1'b0, 2,  1}; // through core
`endif

    rst_n      = 1'b0;
    ena        = 1'b1;
    in_valid   = 1'b0;
    a_byte     = 8'h00;
    b_byte     = 8'h00;
    mul_done   = 1'b0;
    mul_result = 16'h0000;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check(-1, "rst_op_a", {16'd0, op_a}, 32'd0);
    check(-1, "rst_op_b", {16'd0, op_b}, 32'd0);
    check(-1, "rst_start", {31'd0, mul_start}, 32'd0);
    check(-1, "rst_out_byte", {24'd0, out_byte}, 32'd0);
    check(-1, "rst_out_valid", {31'd0, out_valid}, 32'd0);
    check(-1, "rst_busy", {31'd0, busy}, 32'd0);
    check(-1, "rst_err", {31'd0, err_timeout}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_txn(i, vecs[i]);
    end

    // Asynchronous reset in the middle of WAIT.
    in_valid = 1'b1;
    a_byte   = 8'h00;
    b_byte   = 8'h00;
    tick();
    a_byte   = 8'h40;
    b_byte   = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check(-2, "pre_rst_busy", {31'd0, busy}, 32'd1);
    check(-2, "pre_rst_op_a", {16'd0, op_a}, 32'h4000);
    #2 rst_n = 1'b0;
    #1;
    check(-2, "async_rst_op_a", {16'd0, op_a}, 32'd0);
    check(-2, "async_rst_op_b", {16'd0, op_b}, 32'd0);
    check(-2, "async_rst_start", {31'd0, mul_start}, 32'd0);
    check(-2, "async_rst_out_byte", {24'd0, out_byte}, 32'd0);
    check(-2, "async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check(-2, "async_rst_out_last", {31'd0, out_last}, 32'd0);
    check(-2, "async_rst_busy", {31'd0, busy}, 32'd0);
    check(-2, "async_rst_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check(-2, "post_rst_idle", {31'd0, busy}, 32'd0);

    for (int i = 4; i < 7; i++) begin
      run_txn(i, vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/afpm_io_sequencer.md
# afpm_io_sequencer

Operand/result sequencer between the 8-bit Tiny Tapeout pin interface and the 16-bit logarithmic approximate FP16 multiplier core in `tt_um_logarithmic_afpm`. It deserialises two bytes per operand, with the low byte first, from `ui_in` (A) and `uio_in` (B). It then issues a one-cycle start to the core, waits for `mul_done` with a timeout, and serialises the 16-bit result back out low byte first.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles before the result is forced to NaN; range 1–255.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable. When 0, all state, counters and registers hold.
- `in_valid` in 1: the input bytes are valid this cycle.
- `a_byte` in 8: operand A byte (from `ui_in`).
- `b_byte` in 8: operand B byte (from `uio_in`).
- `op_a` out 16: operand A to the core. Stable from START until the return to IDLE.
- `op_b` out 16: operand B to the core. Same stability as `op_a`.
- `mul_start` out 1: one-cycle start pulse to the core.
- `mul_done` in 1: the core result is valid this cycle.
- `mul_result` in 16: core result, sampled when `mul_done`=1.
- `out_byte` out 8: result byte (to `uo_out`).
- `out_valid` out 1: `out_byte` is valid.
- `out_last` out 1: marks the high (final) result byte.
- `busy` out 1: 1 in every state except IDLE and LOAD_HI.
- `err_timeout` out 1: sticky timeout flag.

## Operation
- States: IDLE, LOAD_HI, START, WAIT, OUT_LO, OUT_HI. Encoding is free. All outputs are registered.
- **IDLE:** on `in_valid`, capture `a_byte` → `op_a[7:0]` and `b_byte` → `op_b[7:0]`, clear `err_timeout`, go to LOAD_HI.
- **LOAD_HI:** hold while `in_valid`=0. On `in_valid`, capture `op_a[15:8]` and `op_b[15:8]`, go to START.
- **START:** `mul_start`=1 for exactly one cycle, WAIT counter cleared, go to WAIT.
- **WAIT:**
  - `mul_done`=1: latch `mul_result` into the result register, go to OUT_LO.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, load 16'h7E00 as the result, set `err_timeout`, go to OUT_LO.
  - If `mul_done` arrives in the same cycle as the timeout, `mul_done` wins and no error is flagged.
- **OUT_LO:** `out_byte`=result[7:0], `out_valid`=1, `out_last`=0. Go to OUT_HI.
- **OUT_HI:** `out_byte`=result[15:8], `out_valid`=1, `out_last`=1. Go to IDLE.
- `in_valid` is ignored in START, WAIT, OUT_LO and OUT_HI. Bytes presented there are dropped; there is no queueing.
- `mul_done` outside WAIT is ignored.
- `ena`=0 freezes the FSM, the counter and all outputs at their current values. `mul_start` is not re-pulsed when `ena` returns.
- Reset (including mid-operation) forces IDLE immediately. Reset values:
  - `op_a`=0, `op_b`=0, `mul_start`=0
  - `out_byte`=0, `out_valid`=0, `out_last`=0
  - `busy`=0, `err_timeout`=0
  - result register=0, counter=0
- `out_byte` holds its last value in non-output states; `out_valid`=0 there.

## Timing
- Cycle n: low byte accepted (IDLE, `in_valid`=1).
- Cycle n+1: high byte accepted when `in_valid`=1. Each idle cycle in LOAD_HI shifts everything that follows by one.
- Cycle n+2: `mul_start`=1, with `op_a`/`op_b` already valid.
- WAIT is entered at n+3. `mul_done` is first sampled at n+3.
- If the core asserts `mul_done` at n+2+d (d ≥ 1): OUT_LO at n+3+d, OUT_HI at n+4+d, IDLE at n+5+d.
- Minimum turnaround is low byte → next low byte accepted = 6 cycles (d=1).
- Timeout: WAIT lasts `TIMEOUT`+1 cycles at most, then OUT_LO.

## Configuration
- `AFPM_ZERO_SKIP_EN` defined:
  - In START, if `op_a[14:10]`==0 or `op_b[14:10]`==0, the operand is zero or subnormal and is flushed to zero.
  - `mul_start` is suppressed, the result is set to {`op_a[15]`^`op_b[15]`, 15'b0}, and the FSM goes directly to OUT_LO.
  - Latency from the low byte to OUT_LO is 3 cycles.
- `AFPM_ZERO_SKIP_EN` undefined: every operand pair goes through the core; no exponent check is implemented.

## Test plan
- **Nominal:**
  - Stimulus: A=16'h44DF, B=16'h483D, low bytes DF/3D then high bytes 44/48. The core model returns 16'h5129 with d=3.
  - Response: `op_a`=44DF and `op_b`=483D at `mul_start`. `out_byte`=29 then 51 on consecutive cycles, with `out_last` set on the second.
- **Stall:**
  - Stimulus: `in_valid`=0 for 4 cycles in LOAD_HI, with junk bytes driven during busy states.
  - Response: `mul_start` is delayed by exactly 4 cycles. The junk bytes do not alter `op_a`/`op_b`.
- **Timeout:**
  - Stimulus: `TIMEOUT`=15 and the core never asserts done.
  - Response: `err_timeout`=1 and the output bytes are 00 then 7E. The flag clears on the next accepted low byte.
  - Also check that `mul_done` on the exact timeout cycle yields the core result with `err_timeout`=0.
- **Reset:**
  - Stimulus: `rst_n` pulsed low during WAIT, then a new operand pair.
  - Response: all outputs go to reset values asynchronously. The next transaction completes normally.
- **Enable:**
  - Stimulus: `ena`=0 for 3 cycles during OUT_LO.
  - Response: `out_byte`=result[7:0] with `out_valid` held for those cycles. Exactly one `mul_start` pulse occurs in the transaction.
- **Zero skip:**
  - Stimulus (macro on): A=16'h8000, B=16'h3C00.
  - Response: no `mul_start`; output bytes 00 then 80.
  - With the macro off, the same pair produces a `mul_start` pulse.
